// File: rtl/data_memory_ram.sv
// Word-organised data RAM with byte-lane writes and a combinational CPU read port,
// plus a FETCH/PRESENT dump engine that streams every word out over valid/ready.
module data_memory_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [3:0]            cpu_byte_en_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  input  logic                  dump_start_i,
  input  logic                  dump_ready_i,
  output logic                  dump_valid_o,
  output logic [31:0]           dump_data_o,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic                  dump_last_o,
  output logic                  dump_busy_o,
  output logic                  dump_done_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_e;

  logic [31:0]           mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic [31:0]           dump_data_q, dump_data_d;
  logic                  dump_done_q, dump_done_d;
  logic [ADDR_WIDTH-1:0] cpu_idx;
  logic                  busy;
  logic                  unused_addr_bits;

  // Byte offset and high address bits are dropped, so addresses alias by design.
  assign cpu_idx          = cpu_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_WIDTH+2], cpu_addr_i[1:0]};

  assign busy        = (state_q != S_IDLE);
  assign cpu_rdata_o = mem_q[cpu_idx];

  // Writes are frozen while dumping so the streamed image is a consistent snapshot.
  always_ff @(posedge clk_i) begin
    if (!busy) begin
      for (int n = 0; n < 4; n++) begin
        if (cpu_byte_en_i[n]) begin
          mem_q[cpu_idx][8*n +: 8] <= cpu_wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      dump_done_q <= dump_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    dump_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start_i) begin
          dump_addr_d = '0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        dump_data_d = mem_q[dump_addr_q];
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (dump_ready_i) begin
          if (dump_addr_q == LAST_IDX) begin
            state_d     = S_IDLE;
            dump_done_d = 1'b1;
          end else begin
            dump_addr_d = dump_addr_q + ADDR_WIDTH'(1);
            state_d     = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dump_valid_o = (state_q == S_PRESENT);
  assign dump_data_o  = dump_data_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_last_o  = (state_q == S_PRESENT) && (dump_addr_q == LAST_IDX);
  assign dump_busy_o  = busy;
  assign dump_done_o  = dump_done_q;

endmodule

// File: tb/tb_data_memory_ram.sv
// Bench for data_memory_ram: byte lanes, aliasing, full dumps against a scoreboard,
// backpressure, write blocking during dumps, and reset mid-dump.
module tb_data_memory_ram;
  localparam int AW    = 10;
  localparam int DEPTH = 2 ** AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [31:0]   cpu_addr_i = '0;
  logic [3:0]    cpu_byte_en_i = '0;
  logic [31:0]   cpu_wdata_i = '0;
  logic [31:0]   cpu_rdata_o;
  logic          dump_start_i = 1'b0;
  logic          dump_ready_i = 1'b0;
  logic          dump_valid_o;
  logic [31:0]   dump_data_o;
  logic [AW-1:0] dump_addr_o;
  logic          dump_last_o;
  logic          dump_busy_o;
  logic          dump_done_o;

  data_memory_ram #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_byte_en_i(cpu_byte_en_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .dump_start_i(dump_start_i), .dump_ready_i(dump_ready_i),
    .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o),
    .dump_addr_o(dump_addr_o), .dump_last_o(dump_last_o),
    .dump_busy_o(dump_busy_o), .dump_done_o(dump_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_edge = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Handshake monitor: sampled on the falling edge, inputs only change after a rising edge.
  always @(negedge clk_i) begin
    if (dump_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dump_valid_o && dump_ready_i) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("dump_addr", 64'(dump_addr_o), 64'(e.addr));
        chk("dump_data", 64'(dump_data_o), 64'(e.data));
        chk("dump_last", 64'(dump_last_o), 64'(e.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_addr_i = a; cpu_byte_en_i = be; cpu_wdata_i = d;
    for (int n = 0; n < 4; n++)
      if (be[n]) model[a[AW+1:2]][8*n +: 8] = d[8*n +: 8];
    @(posedge clk_i); #1;
    cpu_byte_en_i = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_addr_i = a; cpu_byte_en_i = '0;
    @(negedge clk_i);
    chk(tag, 64'(cpu_rdata_o), 64'(exp));
    @(posedge clk_i); #1;
  endtask

  task automatic push_all();
    for (int i = 0; i < DEPTH; i++)
      sb.push_back('{addr: AW'(i), data: model[i], last: (i == DEPTH - 1)});
  endtask

  task automatic start_dump(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_addr_i = a; cpu_byte_en_i = be; cpu_wdata_i = d; dump_start_i = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk_i); #1;
    dump_start_i = 1'b0; cpu_byte_en_i = '0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n = 0;
    while (done_cnt == base && n < 3 * DEPTH) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt), 64'(base + 1));
    @(posedge clk_i); #1;
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] old8;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 64'(dump_valid_o), 64'd0);
    chk("rst_busy",  64'(dump_busy_o),  64'd0);
    chk("rst_last",  64'(dump_last_o),  64'd0);
    chk("rst_done",  64'(dump_done_o),  64'd0);
    chk("rst_addr",  64'(dump_addr_o),  64'd0);
    chk("rst_data",  64'(dump_data_o),  64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Byte lanes
    cpu_write(32'h10, 4'b1111, 32'hAABBCCDD);
    read_check("lane_full", 32'h10, 32'hAABBCCDD);
    cpu_write(32'h10, 4'b0100, 32'h00EE0000);
    read_check("lane_2", 32'h10, 32'hAAEECCDD);
    cpu_write(32'h10, 4'b0000, 32'h11223344);
    read_check("lane_none", 32'h10, 32'hAAEECCDD);
    cpu_write(32'h10, 4'b1001, 32'h55667788);
    read_check("lane_0_3", 32'h10, 32'h55EECC88);

    // Aliasing
    cpu_write(32'h1004, 4'b1111, 32'h12345678);
    read_check("alias_hi", 32'h0004, 32'h12345678);
    read_check("alias_b3", 32'h0007, 32'h12345678);

    // Preload mem[i] = i*3
    for (int i = 0; i < DEPTH; i++) cpu_write(32'(i * 4), 4'b1111, 32'(i * 3));
    read_check("preload_9", 32'h24, 32'd27);

    // Same-cycle read returns old data, next cycle new
    old8 = model[8];
    cpu_addr_i = 32'h20; cpu_byte_en_i = 4'b1111; cpu_wdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    chk("same_cycle_old", 64'(cpu_rdata_o), 64'(old8));
    @(posedge clk_i); #1;
    cpu_byte_en_i = '0;
    model[8] = 32'hCAFEF00D;
    read_check("next_cycle_new", 32'h20, 32'hCAFEF00D);
    cpu_write(32'h20, 4'b1111, 32'd24);

    // Full dump, ready held high
    dump_ready_i = 1'b1;
    base = done_cnt;
    push_all();
    start_dump(32'h0, 4'b0000, 32'h0);
    wait_done("dump1", base);
    chk("dump1_latency", 64'(done_cyc - start_edge), 64'(2 * DEPTH));
    chk("dump1_sb_empty", 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk_i); #1;
    chk("dump1_single_done", 64'(done_cnt), 64'(base + 1));

    // Dump with blocked write, repeated start, backpressure, start on last handshake
    base = done_cnt;
    push_all();
    start_dump(32'h0, 4'b0000, 32'h0);
    cpu_addr_i = 32'h0; cpu_byte_en_i = 4'b1111; cpu_wdata_i = 32'hDEADBEEF; dump_start_i = 1'b1;
    @(posedge clk_i); #1;
    dump_start_i = 1'b0; cpu_byte_en_i = '0;
    read_check("read_during_dump", 32'h14, model[5]);
    chk("busy_during_dump", 64'(dump_busy_o), 64'd1);
    n = 0;
    @(negedge clk_i);
    while (!(dump_addr_o == AW'(7) && !dump_valid_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_word7", 64'(n < 100), 64'd1);
    @(posedge clk_i); #1;
    dump_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_valid", 64'(dump_valid_o), 64'd1);
      chk("bp_addr",  64'(dump_addr_o),  64'd7);
      chk("bp_data",  64'(dump_data_o),  64'(model[7]));
    end
    @(posedge clk_i); #1;
    dump_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("bp_fetch_valid", 64'(dump_valid_o), 64'd0);
    chk("bp_fetch_addr",  64'(dump_addr_o),  64'd8);
    @(negedge clk_i);
    chk("bp_w8_valid", 64'(dump_valid_o), 64'd1);
    chk("bp_w8_data",  64'(dump_data_o),  64'(model[8]));
    n = 0;
    while (!dump_last_o && n < 3 * DEPTH) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_last", 64'(dump_last_o), 64'd1);
    #1 dump_start_i = 1'b1;
    @(posedge clk_i); #1;
    dump_start_i = 1'b0;
    wait_done("dump2", base);
    repeat (3) @(posedge clk_i); #1;
    chk("start_on_last_ignored", 64'(dump_busy_o), 64'd0);
    chk("dump2_single_done", 64'(done_cnt), 64'(base + 1));
    chk("dump2_sb_empty", 64'(sb.size()), 64'd0);
    read_check("blocked_write", 32'h0, model[0]);

    // Same-cycle write and start, then reset at word 100
    base = done_cnt;
    model[0] = 32'h0BADF00D;
    push_all();
    start_dump(32'h0, 4'b1111, 32'h0BADF00D);
    n = 0;
    @(negedge clk_i);
    while (!(dump_valid_o && dump_addr_o == AW'(100)) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_word100", 64'(n < 1000), 64'd1);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_valid", 64'(dump_valid_o), 64'd0);
    chk("mid_rst_busy",  64'(dump_busy_o),  64'd0);
    chk("mid_rst_last",  64'(dump_last_o),  64'd0);
    chk("mid_rst_done",  64'(dump_done_o),  64'd0);
    chk("mid_rst_addr",  64'(dump_addr_o),  64'd0);
    repeat (4) @(negedge clk_i);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(base));
    sb.delete();
    @(posedge clk_i); #1;
    read_check("rst_keeps_ram", 32'h0, 32'h0BADF00D);

    // Fresh dump after reset restarts at address 0
    base = done_cnt;
    push_all();
    start_dump(32'h0, 4'b0000, 32'h0);
    wait_done("dump4", base);
    chk("dump4_latency", 64'(done_cyc - start_edge), 64'(2 * DEPTH));
    chk("dump4_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_ram.md
# data_memory_ram

Word-organised data RAM that sits directly downstream of the CPU's load/store alignment stage. It takes that stage's 4-bit byte-enable strobe and lane-aligned write data, and returns the raw 32-bit word for sign/zero extension. It also contains a sequential dump engine. The engine streams every RAM word to the debug unit over a valid/ready handshake, so memory contents can be inspected after the program halts.

## Interface
Parameters:
- ADDR_WIDTH, default 10: word-address bits. Depth DEPTH = 2**ADDR_WIDTH words (default 1024 words = 4 KiB).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- cpu_addr_i  input  32  byte address from the ALU. Word index = cpu_addr_i[ADDR_WIDTH+1:2]. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses alias.
- cpu_byte_en_i  input  4  write strobe; bit n writes byte lane n (bits [8n+7:8n]).
- cpu_wdata_i  input  32  lane-aligned store data.
- cpu_rdata_o  output  32  raw word at the current word index (combinational read).
- dump_start_i  input  1  single-cycle request to start a full-memory dump.
- dump_ready_i  input  1  debug unit can accept a dump word this cycle.
- dump_valid_o  output  1  dump_data_o and dump_addr_o are valid.
- dump_data_o  output  32  dump word.
- dump_addr_o  output  ADDR_WIDTH  word index of dump_data_o.
- dump_last_o  output  1  current dump word is index DEPTH-1.
- dump_busy_o  output  1  dump engine is not IDLE.
- dump_done_o  output  1  one-cycle pulse after the final word is accepted.

## Operation
- **Writes.** At each rising edge, for each lane n with cpu_byte_en_i[n]=1 and dump_busy_o=0, mem[idx][8n+7:8n] is set to cpu_wdata_i[8n+7:8n]. Lanes with a 0 strobe keep their value. A strobe of 4'b0000 writes nothing.
- **CPU reads.** cpu_rdata_o = mem[idx] combinationally. This is required because the core is single-cycle and load extension is combinational downstream.
- **Memory contents.** Not initialised and not cleared by rst_i.
- **Dump FSM.** States IDLE, FETCH, PRESENT.
  - IDLE: on dump_start_i=1, set dump_addr_o=0 and go to FETCH.
  - FETCH: register mem[dump_addr_o] into dump_data_o, then go to PRESENT.
  - PRESENT: dump_valid_o=1. On dump_ready_i=1 (handshake):
    - if dump_addr_o==DEPTH-1: go to IDLE and pulse dump_done_o next cycle;
    - otherwise increment dump_addr_o and go to FETCH.
  - Without ready, remain in PRESENT with dump_data_o and dump_addr_o held stable.
- dump_busy_o = (state != IDLE).
- dump_last_o = PRESENT and dump_addr_o==DEPTH-1.
- CPU writes are suppressed for the whole time dump_busy_o=1, so dumped data is a consistent snapshot. CPU reads are still served.
- dump_start_i is ignored while busy.

## Timing
- Reset values: state=IDLE, dump_valid_o=0, dump_busy_o=0, dump_last_o=0, dump_done_o=0, dump_addr_o=0, dump_data_o=0. cpu_rdata_o reflects RAM contents.
- Write latency: 1 edge. A read of the same address in the next cycle returns the new data. A read in the same cycle returns the old data.
- Dump latency:
  - start accepted at edge k → FETCH during cycle k+1 → dump_valid_o=1 from cycle k+2;
  - each word costs 2 cycles minimum (FETCH + PRESENT) with ready held high;
  - full dump with ready held high is 2·DEPTH cycles after start, plus one cycle for the done pulse.
- Same-cycle CPU write and dump_start_i while IDLE: the write commits. The first FETCH sees the written data.
- dump_addr_o never wraps past DEPTH-1; the dump terminates there.
- Reset mid-dump (rst_i in any state): next edge returns to IDLE with all dump outputs at reset values. No done pulse. RAM contents are unchanged.
- A handshake on the last word and dump_start_i in the same cycle: start is ignored, since the FSM is still busy in that cycle.

## Test plan
- **Byte-lane writes.** Write 0xAABBCCDD with strobe 4'b1111 to address 0x10. Then strobe 4'b0100 with data 0x00EE0000 → read at 0x10 returns 0xAAEECCDD. Then strobe 0000 → unchanged.
- **Aliasing.** With ADDR_WIDTH=10, write 0x12345678 to 0x1004 → read at 0x0004 returns 0x12345678. Address bits [1:0]=3 select the same word.
- **Full dump, ready high.** Preload mem[i]=i*3 and pulse start → DEPTH handshakes, addresses 0..DEPTH-1, data i*3, last asserted only on the final word. dump_done_o pulses once, 2·DEPTH+1 cycles after the start edge.
- **Backpressure.** Hold ready low for 5 cycles at word 7 → valid stays 1, data and address stay stable. Releasing ready yields word 8 two cycles later.
- **Write blocking.** During a dump, drive strobe 1111 with data 0xDEADBEEF to word 0 → the dump shows the original word 0, and after done the read still returns the original value. A repeated start while busy has no effect.
- **Reset mid-dump.** Assert rst_i one cycle at word 100 → valid, busy, last and done are 0 next cycle, no done pulse. A new start then begins again at address 0.
